sevseg_readback: RTL and testbench

Recovers displayed digits from a multiplexed, active-low seven-segment display bus (segments plus digit anodes) and turns them back into BCD values. It is the decode end of the seven-segment display path: it sits beside the display driver and reads back what the oven display is actually showing. Outputs feed the self-check logic and the debug LEDs. Each pattern is validated for stability across scans before it is committed.

---
 rtl/sevseg_pkg.sv | 28 ++
 rtl/sevseg_pattern_decode.sv | 34 +++
 rtl/sevseg_readback.sv | 125 ++++++++++++
 tb/tb_sevseg_readback.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// sevseg_pkg: segment constants, decoded-digit struct and sampler states for sevseg_readback
package sevseg_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] code;
    } digit_t;

    typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_SETTLE = 2'd1, ST_HOLD = 2'd2} state_t;
endpackage

// File: rtl/sevseg_pattern_decode.sv
// sevseg_pattern_decode: active-low 7-seg pattern to BCD/blank; hex letters A-F valid only with SEVSEG_RB_HEX_EN
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg,
    output digit_t     dec
);
    // table lookup; anything unlisted is flagged invalid with code 0
    always_comb begin
        dec = '{valid: 1'b1, blank: 1'b0, code: 4'h0};
        case (seg)
            SEG_0:     dec.code = 4'h0;
            SEG_1:     dec.code = 4'h1;
            SEG_2:     dec.code = 4'h2;
            SEG_3:     dec.code = 4'h3;
            SEG_4:     dec.code = 4'h4;
            SEG_5:     dec.code = 4'h5;
            SEG_6:     dec.code = 4'h6;
            SEG_7:     dec.code = 4'h7;
            SEG_8:     dec.code = 4'h8;
            SEG_9:     dec.code = 4'h9;
            SEG_BLANK: dec.blank = 1'b1;
`ifdef SEVSEG_RB_HEX_EN
            SEG_A:     dec.code = 4'hA;
            SEG_B:     dec.code = 4'hB;
            SEG_C:     dec.code = 4'hC;
            SEG_D:     dec.code = 4'hD;
            SEG_E:     dec.code = 4'hE;
            SEG_F:     dec.code = 4'hF;
`endif
            default:   dec.valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/sevseg_readback.sv
// sevseg_readback: recovers committed digits from a muxed active-low 7-seg bus; hex letters via SEVSEG_RB_HEX_EN
module sevseg_readback
    import sevseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SETTLE       = 2,
    parameter int STABLE_SCANS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  valid_out,
    output logic                  update_out,
    output logic                  err_out,
    output logic [7:0]            err_cnt
);
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(STABLE_SCANS + 1);

    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   an_r, an_prev;
    state_t              state;
    logic [SW-1:0]       scnt;
    digit_t              dec, smp;
    logic                smp_v;
    logic [DW-1:0]       smp_d, sel;
    logic [4*DIGITS-1:0] cand;
    logic [DIGITS-1:0]   cand_blank, seen;
    logic [CW-1:0]       cnt [DIGITS];
    logic [CW-1:0]       ncnt;
    logic                changed, onehot, multi, take, same, commit, differs, err_next;

    sevseg_pattern_decode u_dec (.seg(seg_r), .dec(dec));

    // input registers; an_prev remembers the last selection to detect changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r   <= '1;
            an_r    <= '1;
            an_prev <= '1;
        end else begin
            seg_r   <= seg_in;
            an_r    <= an_in;
            an_prev <= an_r;
        end
    end

    // selection classification, sample strobe and stability next-state
    always_comb begin
        changed  = an_r != an_prev;
        onehot   = $countones(~an_r) == 1;
        multi    = !(&an_r) && !onehot;
        take     = state == ST_SETTLE && !changed && scnt == SW'(SETTLE - 1);
        sel      = '0;
        for (int i = 0; i < DIGITS; i++) if (!an_r[i]) sel = DW'(i);
        same     = smp.code == cand[4*smp_d +: 4] && smp.blank == cand_blank[smp_d];
        ncnt     = !same ? CW'(1) : cnt[smp_d] == CW'(STABLE_SCANS) ? cnt[smp_d] : cnt[smp_d] + 1'b1;
        commit   = smp_v && smp.valid && ncnt == CW'(STABLE_SCANS);
        differs  = smp.code != value_out[4*smp_d +: 4] || smp.blank != blank_out[smp_d];
        err_next = (changed && multi) || (smp_v && !smp.valid);
    end

    // sampler FSM: any selection change restarts from HUNT or SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
            scnt  <= '0;
        end else if (changed) begin
            state <= onehot ? ST_SETTLE : ST_HUNT;
            scnt  <= '0;
        end else if (state == ST_SETTLE) begin
            state <= take ? ST_HOLD : ST_SETTLE;
            scnt  <= scnt + 1'b1;
        end
    end

    // one decoded sample per settled selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_v <= 1'b0;
            smp   <= '0;
            smp_d <= '0;
        end else begin
            smp_v <= take;
            smp   <= dec;
            smp_d <= sel;
        end
    end

    // per-digit candidate tracking, commit, and error accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            cand_blank <= '0;
            for (int i = 0; i < DIGITS; i++) cnt[i] <= '0;
            value_out  <= '0;
            blank_out  <= '1;
            seen       <= '0;
            update_out <= 1'b0;
            err_out    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            update_out <= commit && differs;
            err_out    <= err_next;
            if (err_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (smp_v && !smp.valid) cnt[smp_d] <= '0;
            if (smp_v && smp.valid) begin
                cand[4*smp_d +: 4] <= smp.code;
                cand_blank[smp_d]  <= smp.blank;
                cnt[smp_d]         <= ncnt;
            end
            if (commit) begin
                value_out[4*smp_d +: 4] <= smp.code;
                blank_out[smp_d]        <= smp.blank;
                seen[smp_d]             <= 1'b1;
            end
        end
    end

    assign valid_out = &seen;
endmodule

// File: tb/tb_sevseg_readback.sv
// tb_sevseg_readback: directed vectors for sevseg_readback (hex expectations follow SEVSEG_RB_HEX_EN)
module tb_sevseg_readback;
    import sevseg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value_out;
    logic [3:0]  blank_out;
    logic        valid_out, update_out, err_out;
    logic [7:0]  err_cnt;
    int          n_chk = 0, n_fail = 0, n_upd = 0, n_err = 0, u0 = 0, e0 = 0;

    always #5 clk = ~clk;

    sevseg_readback dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .value_out(value_out), .blank_out(blank_out), .valid_out(valid_out),
        .update_out(update_out), .err_out(err_out), .err_cnt(err_cnt)
    );

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (update_out === 1'b1) n_upd++;
        if (err_out === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        u0 = n_upd;
        e0 = n_err;
    endtask

    task automatic do_reset();
        an_in  = '1;
        seg_in = '1;
        rst_n  = 1'b0;
        step(2);
        rst_n  = 1'b1;
        step(2);
    endtask

    // p holds digit d's pattern in bits [7d+6:7d]; dwell 8 cycles per digit
    task automatic scan(input logic [27:0] p, input int n);
        repeat (n) begin
            for (int d = 0; d < 4; d++) begin
                an_in  = ~(4'b0001 << d);
                seg_in = p[7*d +: 7];
                step(8);
            end
        end
    endtask

    initial begin
        an_in  = '1;
        seg_in = '1;
        rst_n  = 1'b0;
        step(3);
        chk("rst_value", 32'(value_out), 32'h0);
        chk("rst_blank", 32'(blank_out), 32'hF);
        mark();
        rst_n = 1'b1;
        step(20);
        chk("idle_value", 32'(value_out), 32'h0);
        chk("idle_blank", 32'(blank_out), 32'hF);
        chk("idle_valid", 32'(valid_out), 32'h0);
        chk("idle_errcnt", 32'(err_cnt), 32'h0);
        chk("idle_pulses", 32'(n_upd - u0 + n_err - e0), 32'h0);
        chk("idle_fsm", 32'(dut.state), 32'(ST_HUNT));

        mark();
        scan({SEG_4, SEG_3, SEG_2, SEG_1}, 2);
        chk("scan2_upd", 32'(n_upd - u0), 32'h0);
        chk("scan2_valid", 32'(valid_out), 32'h0);
        scan({SEG_4, SEG_3, SEG_2, SEG_1}, 1);
        an_in = '1;
        step(10);
        chk("scan3_value", 32'(value_out), 32'h4321);
        chk("scan3_blank", 32'(blank_out), 32'h0);
        chk("scan3_valid", 32'(valid_out), 32'h1);
        chk("scan3_upd", 32'(n_upd - u0), 32'h4);
        chk("scan3_err", 32'(n_err - e0), 32'h0);

        scan({SEG_9, SEG_5, SEG_8, SEG_7}, 2);
        an_in  = '1;
        seg_in = '1;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_value", 32'(value_out), 32'h0);
        chk("async_rst_valid", 32'(valid_out), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        mark();
        for (int i = 0; i < 4; i++) begin
            scan({SEG_9, (i % 2 == 1) ? SEG_6 : SEG_5, SEG_8, SEG_7}, 1);
            if (i == 1) chk("post_rst_upd", 32'(n_upd - u0), 32'h0);
        end
        an_in = '1;
        step(10);
        chk("toggle_value", 32'(value_out), 32'h9087);
        chk("toggle_blank", 32'(blank_out), 32'h4);
        chk("toggle_valid", 32'(valid_out), 32'h0);
        chk("toggle_upd", 32'(n_upd - u0), 32'h3);

        mark();
        scan({SEG_9, SEG_5, 7'b0101010, SEG_7}, 3);
        an_in = '1;
        step(10);
        chk("inval_err", 32'(n_err - e0), 32'h3);
        chk("inval_errcnt", 32'(err_cnt), 32'h3);
        chk("inval_upd", 32'(n_upd - u0), 32'h1);
        chk("inval_value", 32'(value_out), 32'h9587);
        chk("inval_valid", 32'(valid_out), 32'h1);

        mark();
        an_in = 4'b0011;
        step(1);
        chk("multi_edge1", 32'(err_out), 32'h0);
        step(1);
        chk("multi_edge2", 32'(err_out), 32'h1);
        step(1);
        chk("multi_edge3", 32'(err_out), 32'h0);
        chk("multi_fsm", 32'(dut.state), 32'(ST_HUNT));
        for (int i = 0; i < 300; i++) begin
            an_in = '1;
            step(2);
            an_in = 4'b0011;
            step(2);
        end
        an_in = '1;
        step(5);
        chk("multi_pulses", 32'(n_err - e0), 32'd301);
        chk("multi_errcnt_sat", 32'(err_cnt), 32'd255);
        chk("multi_value", 32'(value_out), 32'h9587);
        chk("multi_upd", 32'(n_upd - u0), 32'h0);

        do_reset();
        mark();
        repeat (3) begin
            an_in  = 4'b1110;
            seg_in = SEG_A;
            step(8);
            an_in  = '1;
            step(8);
        end
`ifdef SEVSEG_RB_HEX_EN
        chk("hex_value", 32'(value_out), 32'h000A);
        chk("hex_blank", 32'(blank_out), 32'hE);
        chk("hex_upd", 32'(n_upd - u0), 32'h1);
        chk("hex_err", 32'(n_err - e0), 32'h0);
`else
        chk("nohex_value", 32'(value_out), 32'h0);
        chk("nohex_blank", 32'(blank_out), 32'hF);
        chk("nohex_upd", 32'(n_upd - u0), 32'h0);
        chk("nohex_err", 32'(n_err - e0), 32'h3);
        chk("nohex_errcnt", 32'(err_cnt), 32'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
